// File: rtl/spi_pkg.sv
// spi_pkg: shared constants, FSM state type and CRC7 helper for the SPI responder.
//   SCLK_IDX/MOSI_IDX/SS_IDX : bit positions inside the {ss_n, mosi, sclk} pin bundle
//   IDLE_BYTE_DFLT           : default MISO word when no tx data is queued
//   spi_slave_state_t        : IDLE (deselected) / ACTIVE (ss_n low)
//   crc7_next()              : advances a CRC7 (x^7+x^3+1) over the low nbits of data, MSB first
package spi_pkg;

   localparam int SCLK_IDX = 0;
   localparam int MOSI_IDX = 1;
   localparam int SS_IDX   = 2;
   localparam int NUM_PINS = 3;

   localparam logic [7:0] IDLE_BYTE_DFLT = 8'hFF;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_slave_state_t;

   function automatic logic [6:0] crc7_next(input logic [6:0] crc,
                                            input logic [31:0] data,
                                            input int unsigned nbits);
      logic [6:0] c;
      logic       fb;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         if (i < int'(nbits)) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: SYNC_STAGES-deep synchroniser followed by a previous-value flop,
// giving a clean level plus single-cycle rise/fall strobes in the clk domain.
//   clk, rst  : system clock, synchronous active-high reset
//   pin_i     : asynchronous input pin
//   level_o   : synchronised level
//   rise_o    : level went 0->1 (combinational from the last two flops)
//   fall_o    : level went 1->0
// RST_VAL is the pin's idle level, so leaving reset produces no false edge.
module spi_pin_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  =  sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-3 slave byte engine (SD-card bus far end).
// Oversamples {ss_n, mosi, sclk} in the clk domain, deserialises MOSI words and
// serialises host words onto MISO through a one-deep tx holding register.
//   clk, rst        : system clock, synchronous active-high reset
//   from_master_i   : [0]=sclk [1]=mosi [2]=ss_n
//   to_master_o     : miso (1 while deselected)
//   rx_dat_o        : last complete received word, held until the next one
//   rx_valid_o      : one-cycle strobe when rx_dat_o updates
//   tx_dat_i/tx_valid_i/tx_ready_o : host tx handshake into the holding register
//   tx_underrun_o   : one-cycle strobe when a word starts with nothing queued
//   crc7_o          : running CRC7 of received words in the current frame
// Optional feature macro: SPI_SLAVE_CRC7_EN (undefined: crc7_o tied to 0).
module spi_slave_responder
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = DATA_WIDTH'(IDLE_BYTE_DFLT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            from_master_i,
   output logic                  to_master_o,
   output logic [DATA_WIDTH-1:0] rx_dat_o,
   output logic                  rx_valid_o,
   input  logic [DATA_WIDTH-1:0] tx_dat_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic                  tx_underrun_o,
   output logic [6:0]            crc7_o
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [NUM_PINS-1:0] lvl, rise, fall;

   genvar g;
   generate
      for (g = 0; g < NUM_PINS; g++) begin : g_pin
         spi_pin_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .RST_VAL     ((g == MOSI_IDX) ? 1'b0 : 1'b1)
         ) u_sync (
            .clk     (clk),
            .rst     (rst),
            .pin_i   (from_master_i[g]),
            .level_o (lvl[g]),
            .rise_o  (rise[g]),
            .fall_o  (fall[g])
         );
      end
   endgenerate

   logic unused_pins;
   assign unused_pins = ^{lvl[SCLK_IDX], lvl[SS_IDX], rise[MOSI_IDX], fall[MOSI_IDX]};

   spi_slave_state_t      state_q;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [DATA_WIDTH-1:0] rx_sh_q, tx_sh_q, hold_q, rx_dat_q;
   logic                  miso_q, rx_valid_q, tx_ready_q, underrun_q;
   logic [DATA_WIDTH-1:0] rx_sh_d;
   logic                  last_bit;

   assign rx_sh_d  = {rx_sh_q[DATA_WIDTH-2:0], lvl[MOSI_IDX]};
   assign last_bit = (bit_cnt_q == CNT_W'(DATA_WIDTH-1));

`ifdef SPI_SLAVE_CRC7_EN
   logic [6:0] crc_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         rx_sh_q    <= '0;
         tx_sh_q    <= '0;
         hold_q     <= '0;
         rx_dat_q   <= '0;
         miso_q     <= 1'b1;
         rx_valid_q <= 1'b0;
         tx_ready_q <= 1'b1;
         underrun_q <= 1'b0;
`ifdef SPI_SLAVE_CRC7_EN
         crc_q      <= '0;
`endif
      end else begin
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;

         // Accept needs an empty holding reg and consume needs a full one, so
         // they never fight over tx_ready_q. A same-cycle consume sees empty.
         if (tx_valid_i && tx_ready_q) begin
            hold_q     <= tx_dat_i;
            tx_ready_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               miso_q    <= 1'b1;
               bit_cnt_q <= '0;
               rx_sh_q   <= '0;
               tx_sh_q   <= '0;
               if (fall[SS_IDX]) begin
                  state_q <= ACTIVE;
`ifdef SPI_SLAVE_CRC7_EN
                  crc_q   <= '0;
`endif
               end
            end

            ACTIVE: begin
               if (rise[SS_IDX]) begin
                  // Abort: partial words are dropped, holding reg survives.
                  state_q   <= IDLE;
                  miso_q    <= 1'b1;
                  bit_cnt_q <= '0;
               end else begin
                  if (fall[SCLK_IDX]) begin
                     if (bit_cnt_q == '0) begin
                        if (!tx_ready_q) begin
                           tx_sh_q    <= hold_q;
                           miso_q     <= hold_q[DATA_WIDTH-1];
                           tx_ready_q <= 1'b1;
                        end else begin
                           tx_sh_q    <= IDLE_BYTE;
                           miso_q     <= IDLE_BYTE[DATA_WIDTH-1];
                           underrun_q <= 1'b1;
                        end
                     end else begin
                        tx_sh_q <= tx_sh_q << 1;
                        miso_q  <= tx_sh_q[DATA_WIDTH-2];
                     end
                  end

                  if (rise[SCLK_IDX]) begin
                     rx_sh_q <= rx_sh_d;
                     if (last_bit) begin
                        bit_cnt_q  <= '0;
                        rx_dat_q   <= rx_sh_d;
                        rx_valid_q <= 1'b1;
`ifdef SPI_SLAVE_CRC7_EN
                        crc_q      <= crc7_next(crc_q, 32'(rx_sh_d), DATA_WIDTH);
`endif
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                     end
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign to_master_o   = miso_q;
   assign rx_dat_o      = rx_dat_q;
   assign rx_valid_o    = rx_valid_q;
   assign tx_ready_o    = tx_ready_q;
   assign tx_underrun_o = underrun_q;

`ifdef SPI_SLAVE_CRC7_EN
   assign crc7_o = crc_q;
`else
   assign crc7_o = 7'd0;
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: directed SPI master tasks plus a transaction-level
// model (expected rx word queue, frame word list, CRC7 by polynomial long division).
module tb_spi_slave_responder;

   localparam int SYNC = 2;
   localparam int HALF = 6;   // clk cycles per sclk phase

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b1, mosi = 1'b0, ss_n = 1'b1;
   logic [7:0] tx_dat = 8'h00;
   logic       tx_valid = 1'b0;
   logic       miso, rx_valid, tx_ready, tx_underrun;
   logic [7:0] rx_dat;
   logic [6:0] crc7;

   always #10 clk = ~clk;

   spi_slave_responder #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
      .clk           (clk),
      .rst           (rst),
      .from_master_i ({ss_n, mosi, sclk}),
      .to_master_o   (miso),
      .rx_dat_o      (rx_dat),
      .rx_valid_o    (rx_valid),
      .tx_dat_i      (tx_dat),
      .tx_valid_i    (tx_valid),
      .tx_ready_o    (tx_ready),
      .tx_underrun_o (tx_underrun),
      .crc7_o        (crc7)
   );

   int checks = 0;
   int errors = 0;
   int underruns = 0;
   int ss_hi_cnt = 0;
   logic [7:0] exp_rx_q[$];
   logic [7:0] frame_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
   function automatic logic [6:0] model_crc();
      logic [7:0] rem;
      logic       b;
      rem = 8'h00;
      for (int w = 0; w < frame_q.size(); w++)
         for (int i = 7; i >= 0; i--) begin
            b   = frame_q[w][i];
            rem = {rem[6:0], b};
            if (rem[7]) rem = rem ^ 8'h89;
         end
      for (int i = 0; i < 7; i++) begin
         rem = {rem[6:0], 1'b0};
         if (rem[7]) rem = rem ^ 8'h89;
      end
      return rem[6:0];
   endfunction

   // Compare process: rx words against the expected queue, CRC alongside each
   // word, MISO idle level while deselected, underrun strobe count.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            if (exp_rx_q.size() == 0) begin
               chk("rx_unexpected", 32'(rx_dat), 32'hDEAD);
            end else begin
               chk("rx_dat", 32'(rx_dat), 32'(exp_rx_q[0]));
               frame_q.push_back(exp_rx_q.pop_front());
`ifdef SPI_SLAVE_CRC7_EN
               chk("crc7_run", 32'(crc7), 32'(model_crc()));
`else
               chk("crc7_off", 32'(crc7), 32'd0);
`endif
            end
         end
         if (tx_underrun) underruns++;
         ss_hi_cnt = ss_n ? ss_hi_cnt + 1 : 0;
         if (ss_hi_cnt > SYNC + 3) chk("miso_idle", 32'(miso), 32'd1);
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ss_begin();
      frame_q.delete();
      ss_n = 1'b0;
      clks(HALF);
   endtask

   task automatic ss_end();
      clks(HALF);
      ss_n = 1'b1;
      clks(10);
   endtask

   // Mode 3: drive mosi on the falling edge, sample miso just before rising.
   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rd);
      rd = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b0;
         mosi = tx[7-i];
         clks(HALF);
         rd   = {rd[6:0], miso};
         sclk = 1'b1;
         if (i == 7) exp_rx_q.push_back(tx);
         clks(HALF);
      end
   endtask

   task automatic push_tx(input logic [7:0] d);
      int n;
      n = 0;
      while (!tx_ready && n < 200) begin
         clks(1);
         n++;
      end
      if (n >= 200) chk("tx_ready_timeout", 32'd0, 32'd1);
      tx_dat   = d;
      tx_valid = 1'b1;
      clks(1);
      tx_valid = 1'b0;
   endtask

   logic [7:0] rd;
   int         u0;
   int         rx_seen;

   initial begin
      // Reset state
      clks(3);
      chk("rst_miso", 32'(miso), 32'd1);
      chk("rst_rx_dat", 32'(rx_dat), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_underrun", 32'(tx_underrun), 32'd0);
      chk("rst_crc7", 32'(crc7), 32'd0);
      rst = 1'b0;

      // 1: idle 100 cycles, nothing happens
      rx_seen = 0;
      for (int i = 0; i < 100; i++) begin
         clks(1);
         if (rx_valid) rx_seen++;
      end
      chk("t1_no_rx_valid", 32'(rx_seen), 32'd0);
      chk("t1_tx_ready", 32'(tx_ready), 32'd1);
      chk("t1_miso", 32'(miso), 32'd1);

      // 2: queued A5 goes out while 40 comes in
      u0 = underruns;
      push_tx(8'hA5);
      clks(1);
      chk("t2_tx_ready_full", 32'(tx_ready), 32'd0);
      ss_begin();
      xfer(8'h40, 8, rd);
      chk("t2_master_rd", 32'(rd), 32'hA5);
      chk("t2_rx_dat_lit", 32'(rx_dat), 32'h40);
      chk("t2_tx_ready_empty", 32'(tx_ready), 32'd1);
      ss_end();
      chk("t2_underruns", 32'(underruns - u0), 32'd0);

      // 3: nothing queued for two words
      u0 = underruns;
      ss_begin();
      xfer(8'h12, 8, rd);
      chk("t3_rd0", 32'(rd), 32'hFF);
      xfer(8'h34, 8, rd);
      chk("t3_rd1", 32'(rd), 32'hFF);
      ss_end();
      chk("t3_underruns", 32'(underruns - u0), 32'd2);

      // 4: abort after 5 bits, then a full 3C
      ss_begin();
      xfer(8'hC3, 5, rd);
      ss_n = 1'b1;
      clks(20);
      chk("t4_miso_between", 32'(miso), 32'd1);
      ss_begin();
      xfer(8'h3C, 8, rd);
      chk("t4_rd", 32'(rd), 32'hFF);
      chk("t4_rx_dat_lit", 32'(rx_dat), 32'h3C);
      ss_end();

      // 5: CMD0 frame
      ss_begin();
      xfer(8'h40, 8, rd);
      for (int i = 0; i < 4; i++) xfer(8'h00, 8, rd);
      clks(2);
`ifdef SPI_SLAVE_CRC7_EN
      chk("t5_crc7_lit", 32'(crc7), 32'h4A);
      chk("t5_model_lit", 32'(model_crc()), 32'h4A);
`else
      chk("t5_crc7_off", 32'(crc7), 32'd0);
`endif
      ss_end();
      ss_begin();
      chk("t5_crc7_cleared", 32'(crc7), 32'd0);
      ss_end();

      // 6: tx_valid lands on the consume cycle of the word start
      u0 = underruns;
      ss_begin();
      fork
         xfer(8'h81, 8, rd);
         begin
            clks(2);
            tx_dat   = 8'h5A;
            tx_valid = 1'b1;
            clks(1);
            tx_valid = 1'b0;
         end
      join
      chk("t6_rd0", 32'(rd), 32'hFF);
      chk("t6_tx_ready_full", 32'(tx_ready), 32'd0);
      xfer(8'h7E, 8, rd);
      chk("t6_rd1", 32'(rd), 32'h5A);
      ss_end();
      chk("t6_underruns", 32'(underruns - u0), 32'd1);

      clks(10);
      chk("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
